ram_mp: RTL and testbench
=========================

# ram_mp

Multi-channel, parametrised successor to the single-channel valid/ready RAM. CHANNELS independent write requesters and CHANNELS independent read requesters share one simple-dual-port array: one write and one read per cycle, each side arbitrated round-robin. Adds byte-strobed writes, write-first read bypass and an optional post-reset zero-fill sweep. Sits under the switch packet buffer and descriptor tables, where several port engines share one storage array.

## Interface
- WIDTH, 8, data word width in bits; must be a multiple of BYTE_WIDTH.
- DEPTH, 8, number of words; need not be a power of two.
- CHANNELS, 2, number of write requesters and number of read requesters (≥1).
- BYTE_WIDTH, 8, bits per write strobe lane.
- CLEAR_ON_RESET, 1, 1 = zero-fill the whole array after reset.
- Derived constants: AW = max(1, $clog2(DEPTH)); SW = WIDTH/BYTE_WIDTH.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- write_valid  in  CHANNELS  per-channel write request.
- write_ready  out  CHANNELS  per-channel write grant.
- write_address  in  CHANNELS*AW  packed; channel i at [i*AW +: AW].
- write_data  in  CHANNELS*WIDTH  packed per channel.
- write_strobe  in  CHANNELS*SW  packed per channel; bit j enables byte lane j.
- read_valid  in  CHANNELS  per-channel read request.
- read_ready  out  CHANNELS  per-channel read grant.
- read_address  in  CHANNELS*AW  packed per channel.
- read_data_valid  out  CHANNELS  one-cycle pulse marking the returned word for channel i.
- read_data  out  WIDTH  shared return bus; qualified by read_data_valid.
- busy  out  1  high during the zero-fill sweep.

## Operation
- Handshake: a transfer occurs on a channel when valid && ready at a rising edge. Requesters hold valid, address, data and strobe stable until ready.
- Arbitration: write and read sides each use a round-robin pointer, reset value 0. Grant goes to the first requesting channel at or after the pointer (wrapping). After a handshake the pointer moves to granted+1 mod CHANNELS; with no handshake it holds. At most one ready per side is high in any cycle.
- ready is combinational from valid and the pointer. It is forced to 0 while busy or reset.
- Write: each byte lane with its strobe bit set is updated; unstrobed lanes keep their old value. write_strobe = 0 completes the handshake with no change to the array.
- Read: the addressed word is registered onto read_data, and read_data_valid[granted] pulses.
- Write-first bypass: if the read and write handshakes in one cycle hit the same address, the read returns the merged word (strobed lanes new, others old).
- Out-of-range address (≥ DEPTH): the handshake still completes. A write is dropped; a read returns 0.
- Zero-fill (CLEAR_ON_RESET=1): after reset deasserts, a sweep counter writes 0 to addresses 0..DEPTH-1, one per cycle, with busy=1. busy drops after the last address. Reset asserted mid-sweep restarts it from 0. With CLEAR_ON_RESET=0, busy is always 0 and contents are undefined after power-up.

## Timing
- Reset values: write_ready=0, read_ready=0, read_data_valid=0, read_data=0, busy=CLEAR_ON_RESET. Both pointers 0; sweep counter 0.
- Write latency: data is visible to a read accepted in the cycle after the write (bypass makes it visible in the same cycle).
- Read latency: 1 cycle. A request accepted at edge t gives read_data_valid and read_data valid in cycle t+1, held for exactly one cycle. read_data then holds its value; read_data_valid returns to 0.
- Throughput: 1 write + 1 read per cycle sustained. With all channels requesting, each channel is granted every CHANNELS cycles.
- Zero-fill lasts exactly DEPTH cycles: with reset released before edge 0, busy=0 and ready is available from cycle DEPTH.

## Structure
- Package ram_pkg: function ram_aw(depth) returning max(1, $clog2(depth)); strobe-width helper; constants for default parameter values.
- Sub-module rr_arbiter (parameter N; ports: request, advance, grant one-hot, grant_index). Instantiated once for the write side and once for the read side.
- Array, bypass merge, output register and sweep counter live in ram_mp.

## Test plan
- Reset, CLEAR_ON_RESET=1, DEPTH=8 -> busy high 8 cycles, all ready 0; then read address 0..7 -> all return 0x00.
- Channel 0 writes 0xA5 to address 3 at cycle t; channel 1 reads address 3 at t+1 -> read_data_valid[1]=1 and read_data=0xA5 at t+2.
- WIDTH=16, address 2 holds 0x1234; write 0xABCD with strobe 2'b10 and read address 2 in the same cycle -> read returns 0xAB34, array holds 0xAB34.
- CHANNELS=3, all write_valid held high for 6 cycles -> grants 0,1,2,0,1,2; drop channel 1 -> sequence 0,2,0,2.
- DEPTH=6: write to address 7 completes the handshake and changes nothing; read address 7 -> 0x00.
- Assert reset for 1 cycle at sweep cycle 4 -> busy stays high a further full DEPTH cycles; read_data_valid stays 0 throughout.

Source files
------------

// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_pkg
// Description : Shared constants and sizing helpers for the multi-channel RAM
//               and its round-robin arbiters.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

    // Default parameter values for ram_mp
    localparam int c_default_width          = 8;
    localparam int c_default_depth          = 8;
    localparam int c_default_channels       = 2;
    localparam int c_default_byte_width     = 8;
    localparam int c_default_clear_on_reset = 1;

    // Address width: at least one bit even for a single-word array
    function automatic int ram_aw(input int depth);
        int a;
        a = $clog2(depth);
        return (a < 1) ? 1 : a;
    endfunction

    // Number of byte-strobe lanes in one data word
    function automatic int ram_sw(input int width, input int byte_width);
        return width / byte_width;
    endfunction

    // Width of a channel index: at least one bit even for a single channel
    function automatic int ram_iw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. Grants the first requester at or after
//               the pointer (wrapping); the pointer moves past the granted
//               channel whenever advance is high, and holds otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import ram_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           request,
    input  logic                   advance,
    output logic [N-1:0]           grant,
    output logic [ram_iw(N)-1:0]   grant_index
);

    localparam int              IW     = ram_iw(N);
    localparam logic [IW-1:0]   c_last = IW'(N - 1);

    logic [IW-1:0] r_ptr_q;
    logic [IW-1:0] w_ptr_d;
    logic [IW-1:0] w_idx;
    logic          w_found;
    int            w_cand;

    // Search the request vector starting at the pointer, wrapping at N
    always_comb begin
        w_found = 1'b0;
        w_idx   = r_ptr_q;
        w_cand  = 0;
        for (int k = 0; k < N; k++) begin
            w_cand = int'(r_ptr_q) + k;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            if (!w_found && request[w_cand]) begin
                w_found = 1'b1;
                w_idx   = IW'(w_cand);
            end
        end
    end

    // One-hot grant and its index
    always_comb begin
        grant = '0;
        if (w_found) begin
            grant[w_idx] = 1'b1;
        end
        grant_index = w_idx;
    end

    // Pointer moves to granted+1 (mod N) only on an accepted grant
    always_comb begin
        w_ptr_d = r_ptr_q;
        if (advance && w_found) begin
            w_ptr_d = (w_idx == c_last) ? '0 : w_idx + 1'b1;
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr_q <= '0;
        end else begin
            r_ptr_q <= w_ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_mp.sv
`default_nettype none
// ============================================================================
// Module      : ram_mp
// Description : Multi-channel simple-dual-port RAM. CHANNELS write and
//               CHANNELS read requesters share one array through round-robin
//               arbiters (one write and one read per cycle). Byte-strobed
//               writes, write-first read bypass, out-of-range tolerance and
//               an optional post-reset zero-fill sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_mp
    import ram_pkg::*;
#(
    parameter  int WIDTH          = c_default_width,
    parameter  int DEPTH          = c_default_depth,
    parameter  int CHANNELS       = c_default_channels,
    parameter  int BYTE_WIDTH     = c_default_byte_width,
    parameter  int CLEAR_ON_RESET = c_default_clear_on_reset,
    localparam int AW             = ram_aw(DEPTH),
    localparam int SW             = ram_sw(WIDTH, BYTE_WIDTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [CHANNELS-1:0]      write_valid,
    output logic [CHANNELS-1:0]      write_ready,
    input  logic [CHANNELS*AW-1:0]   write_address,
    input  logic [CHANNELS*WIDTH-1:0] write_data,
    input  logic [CHANNELS*SW-1:0]   write_strobe,
    input  logic [CHANNELS-1:0]      read_valid,
    output logic [CHANNELS-1:0]      read_ready,
    input  logic [CHANNELS*AW-1:0]   read_address,
    output logic [CHANNELS-1:0]      read_data_valid,
    output logic [WIDTH-1:0]         read_data,
    output logic                     busy
);

    localparam int              IW          = ram_iw(CHANNELS);
    localparam logic [AW:0]     c_depth     = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]   c_last_addr = AW'(DEPTH - 1);
    localparam logic            c_clear     = (CLEAR_ON_RESET != 0);

    // Sweep state machine: RUN serves requests, CLEAR zero-fills the array
    localparam logic [0:0]      c_st_run    = 1'b0;
    localparam logic [0:0]      c_st_clear  = 1'b1;
    localparam logic [0:0]      c_st_reset  = c_clear ? c_st_clear : c_st_run;

    // ------------------------------------------------------------------------
    // Storage and registers
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]    r_mem_q [DEPTH];
    logic [0:0]          r_state_q,  w_state_d;
    logic [AW-1:0]       r_sweep_q,  w_sweep_d;
    logic [WIDTH-1:0]    r_rdata_q,  w_rdata_d;
    logic [CHANNELS-1:0] r_rvalid_q, w_rvalid_d;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic                w_block;
    logic [CHANNELS-1:0] w_wr_req,   w_rd_req;
    logic [CHANNELS-1:0] w_wr_grant, w_rd_grant;
    logic [IW-1:0]       w_wr_idx,   w_rd_idx;
    logic                w_wr_fire,  w_rd_fire;

    // Nobody is granted during reset or while the sweep owns the array
    assign w_block   = reset | (r_state_q == c_st_clear);
    assign w_wr_req  = write_valid & {CHANNELS{~w_block}};
    assign w_rd_req  = read_valid  & {CHANNELS{~w_block}};

    // A grant is only given to a valid requester, so any grant is a handshake
    assign w_wr_fire = |w_wr_grant;
    assign w_rd_fire = |w_rd_grant;

    rr_arbiter #(.N(CHANNELS)) u_wr_arb (
        .clk         (clock),
        .rst         (reset),
        .request     (w_wr_req),
        .advance     (w_wr_fire),
        .grant       (w_wr_grant),
        .grant_index (w_wr_idx)
    );

    rr_arbiter #(.N(CHANNELS)) u_rd_arb (
        .clk         (clock),
        .rst         (reset),
        .request     (w_rd_req),
        .advance     (w_rd_fire),
        .grant       (w_rd_grant),
        .grant_index (w_rd_idx)
    );

    assign write_ready = w_wr_grant;
    assign read_ready  = w_rd_grant;

    // ------------------------------------------------------------------------
    // Select the granted channel's request fields
    // ------------------------------------------------------------------------
    logic [AW-1:0]    w_wr_addr, w_rd_addr;
    logic [WIDTH-1:0] w_wr_data;
    logic [SW-1:0]    w_wr_strb;

    // Mux request fields by granted channel index
    always_comb begin
        w_wr_addr = '0;
        w_wr_data = '0;
        w_wr_strb = '0;
        w_rd_addr = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_wr_idx == IW'(i)) begin
                w_wr_addr = write_address[i*AW +: AW];
                w_wr_data = write_data[i*WIDTH +: WIDTH];
                w_wr_strb = write_strobe[i*SW +: SW];
            end
            if (w_rd_idx == IW'(i)) begin
                w_rd_addr = read_address[i*AW +: AW];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Write merge and bypass
    // ------------------------------------------------------------------------
    logic             w_wr_in, w_rd_in;
    logic [WIDTH-1:0] w_wr_old;
    logic [WIDTH-1:0] w_merged;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_rd_word;

    // Addresses at or beyond DEPTH still handshake but never touch the array
    assign w_wr_in  = ({1'b0, w_wr_addr} < c_depth);
    assign w_rd_in  = ({1'b0, w_rd_addr} < c_depth);
    assign w_wr_old = w_wr_in ? r_mem_q[w_wr_addr] : '0;
    assign w_wr_en  = w_wr_fire & w_wr_in & (|w_wr_strb);

    // Strobed lanes take new data, the rest keep the stored word
    always_comb begin
        w_merged = w_wr_old;
        for (int j = 0; j < SW; j++) begin
            if (w_wr_strb[j]) begin
                w_merged[j*BYTE_WIDTH +: BYTE_WIDTH] = w_wr_data[j*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Read word: zero when out of range, merged word on a same-address write
    always_comb begin
        if (!w_rd_in) begin
            w_rd_word = '0;
        end else if (w_wr_en && (w_wr_addr == w_rd_addr)) begin
            w_rd_word = w_merged;
        end else begin
            w_rd_word = r_mem_q[w_rd_addr];
        end
    end

    // ------------------------------------------------------------------------
    // Read return register
    // ------------------------------------------------------------------------

    // Capture the word on a read handshake; hold it otherwise, valid pulses once
    always_comb begin
        w_rdata_d  = w_rd_fire ? w_rd_word : r_rdata_q;
        w_rvalid_d = w_rd_grant;
    end

    // Return data and per-channel valid registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdata_q  <= '0;
            r_rvalid_q <= '0;
        end else begin
            r_rdata_q  <= w_rdata_d;
            r_rvalid_q <= w_rvalid_d;
        end
    end

    assign read_data       = r_rdata_q;
    assign read_data_valid = r_rvalid_q;

    // ------------------------------------------------------------------------
    // Zero-fill sweep
    // ------------------------------------------------------------------------

    // Step through every address once, then hand the array to the requesters
    always_comb begin
        w_state_d = r_state_q;
        w_sweep_d = r_sweep_q;
        case (r_state_q)
            c_st_clear: begin
                if (r_sweep_q == c_last_addr) begin
                    w_state_d = c_st_run;
                    w_sweep_d = '0;
                end else begin
                    w_sweep_d = r_sweep_q + 1'b1;
                end
            end
            default: begin
                w_state_d = c_st_run;
            end
        endcase
    end

    // Sweep state and counter; reset restarts the sweep from address 0
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q <= c_st_reset;
            r_sweep_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_sweep_q <= w_sweep_d;
        end
    end

    assign busy = (r_state_q == c_st_clear);

    // ------------------------------------------------------------------------
    // Array write port (not reset; the sweep provides the cleared state)
    // ------------------------------------------------------------------------

    // Sweep zeroes have priority; requests are blocked while sweeping anyway
    always_ff @(posedge clock) begin
        if (!reset && (r_state_q == c_st_clear)) begin
            r_mem_q[r_sweep_q] <= '0;
        end else if (!reset && w_wr_en) begin
            r_mem_q[w_wr_addr] <= w_merged;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_mp.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ram_mp
// Description : Scoreboard bench for ram_mp with WIDTH=16, DEPTH=6,
//               CHANNELS=3, BYTE_WIDTH=8, CLEAR_ON_RESET=1. Stimulus pushes
//               the expected read return into a queue; a monitor pops and
//               compares whenever read_data_valid is due or asserted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_mp;

    localparam int c_w  = 16;
    localparam int c_d  = 6;
    localparam int c_ch = 3;
    localparam int c_aw = 3;
    localparam int c_sw = 2;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic [c_ch-1:0]      write_valid = '0;
    logic [c_ch-1:0]      write_ready;
    logic [c_ch*c_aw-1:0] write_address = '0;
    logic [c_ch*c_w-1:0]  write_data = '0;
    logic [c_ch*c_sw-1:0] write_strobe = '0;
    logic [c_ch-1:0]      read_valid = '0;
    logic [c_ch-1:0]      read_ready;
    logic [c_ch*c_aw-1:0] read_address = '0;
    logic [c_ch-1:0]      read_data_valid;
    logic [c_w-1:0]       read_data;
    logic                 busy;

    typedef struct {
        int              due;
        logic [c_ch-1:0] onehot;
        logic [c_w-1:0]  data;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;

    ram_mp #(
        .WIDTH          (c_w),
        .DEPTH          (c_d),
        .CHANNELS       (c_ch),
        .BYTE_WIDTH     (8),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .write_valid     (write_valid),
        .write_ready     (write_ready),
        .write_address   (write_address),
        .write_data      (write_data),
        .write_strobe    (write_strobe),
        .read_valid      (read_valid),
        .read_ready      (read_ready),
        .read_address    (read_address),
        .read_data_valid (read_data_valid),
        .read_data       (read_data),
        .busy            (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: compares the due return, and flags any unexpected valid
    always @(negedge clock) begin : mon
        exp_t e;
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            chk("rd_valid", 32'(read_data_valid), 32'(e.onehot));
            chk("rd_data", 32'(read_data), 32'(e.data));
        end else if (read_data_valid !== '0) begin
            chk("rd_valid_unexpected", 32'(read_data_valid), 32'd0);
        end
    end

    task automatic set_wr(input int ch, input logic [c_aw-1:0] addr,
                          input logic [c_w-1:0] data, input logic [c_sw-1:0] strb);
        write_address[ch*c_aw +: c_aw] = addr;
        write_data[ch*c_w +: c_w]      = data;
        write_strobe[ch*c_sw +: c_sw]  = strb;
        write_valid[ch]                = 1'b1;
    endtask

    task automatic set_rd(input int ch, input logic [c_aw-1:0] addr);
        read_address[ch*c_aw +: c_aw] = addr;
        read_valid[ch]                = 1'b1;
    endtask

    // One cycle: check expected grants, queue expected read return, advance
    task automatic step(input logic [c_ch-1:0] exp_wr, input logic [c_ch-1:0] exp_rd,
                        input logic [c_w-1:0] exp_data, input bit drop);
        exp_t e;
        @(negedge clock);
        chk("write_ready", 32'(write_ready), 32'(exp_wr));
        chk("read_ready", 32'(read_ready), 32'(exp_rd));
        if (exp_rd != '0) begin
            e.due    = cyc + 1;
            e.onehot = exp_rd;
            e.data   = exp_data;
            sb_q.push_back(e);
        end
        @(posedge clock);
        #1;
        if (drop) begin
            write_valid = write_valid & ~exp_wr;
            read_valid  = read_valid & ~exp_rd;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1);
    end

    initial begin
        int n;
        logic [c_w-1:0] exp_mem [c_d];
        exp_mem = '{16'h0000, 16'h0000, 16'hAB78, 16'h00A5, 16'h0000, 16'h0000};

        // Reset with every requester asserted: nothing may be granted
        write_valid = '1;
        read_valid  = '1;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        chk("reset_write_ready", 32'(write_ready), 32'd0);
        chk("reset_read_ready", 32'(read_ready), 32'd0);
        chk("reset_rd_valid", 32'(read_data_valid), 32'd0);
        chk("reset_rd_data", 32'(read_data), 32'd0);
        chk("reset_busy", 32'(busy), 32'd1);
        @(posedge clock);
        #1 reset = 1'b0;

        // Sweep in progress: busy, still no grants
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("sweep_busy", 32'(busy), 32'd1);
        chk("sweep_ready", 32'({write_ready, read_ready}), 32'd0);

        // Reset for one cycle at sweep cycle 4 restarts the full sweep
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        n = 0;
        @(negedge clock);
        while (busy === 1'b1 && n < 20) begin
            n++;
            chk("busy_ready", 32'({write_ready, read_ready}), 32'd0);
            @(negedge clock);
        end
        chk("sweep_cycles", 32'(n), 32'(c_d));
        chk("post_sweep_write_ready", 32'(write_ready), 32'b001);
        chk("post_sweep_read_ready", 32'(read_ready), 32'b001);
        write_valid = '0;
        read_valid  = '0;
        @(posedge clock);
        #1;

        // Every word reads back as zero after the sweep
        for (int a = 0; a < c_d; a++) begin
            set_rd(a % c_ch, c_aw'(a));
            step('0, c_ch'(1 << (a % c_ch)), 16'h0000, 1'b1);
        end

        // Write then read on the next cycle from another channel
        set_wr(0, 3'd3, 16'h00A5, 2'b11);
        step(3'b001, 3'b000, 16'h0000, 1'b1);
        set_rd(1, 3'd3);
        step(3'b000, 3'b010, 16'h00A5, 1'b1);

        // Byte strobe with same-cycle bypass
        set_wr(2, 3'd2, 16'h1234, 2'b11);
        step(3'b100, 3'b000, 16'h0000, 1'b1);
        set_wr(1, 3'd2, 16'hABCD, 2'b10);
        set_rd(0, 3'd2);
        step(3'b010, 3'b001, 16'hAB34, 1'b1);
        set_rd(2, 3'd2);
        step(3'b000, 3'b100, 16'hAB34, 1'b1);

        // Zero strobe: handshake completes, nothing changes (bypass included)
        set_wr(0, 3'd2, 16'hFFFF, 2'b00);
        set_rd(1, 3'd2);
        step(3'b001, 3'b010, 16'hAB34, 1'b1);
        set_rd(0, 3'd2);
        step(3'b000, 3'b001, 16'hAB34, 1'b1);

        // Low lane only
        set_wr(2, 3'd2, 16'h5678, 2'b01);
        step(3'b100, 3'b000, 16'h0000, 1'b1);
        set_rd(1, 3'd2);
        step(3'b000, 3'b010, 16'hAB78, 1'b1);

        // Out-of-range writes drop, out-of-range reads return zero
        set_wr(0, 3'd7, 16'hDEAD, 2'b11);
        step(3'b001, 3'b000, 16'h0000, 1'b1);
        set_wr(1, 3'd6, 16'hBEEF, 2'b11);
        set_rd(2, 3'd6);
        step(3'b010, 3'b100, 16'h0000, 1'b1);
        set_rd(0, 3'd7);
        step(3'b000, 3'b001, 16'h0000, 1'b1);
        for (int a = 0; a < c_d; a++) begin
            set_rd(1, c_aw'(a));
            step(3'b000, 3'b010, exp_mem[a], 1'b1);
        end

        // Sustained requests on all channels: both pointers sit at 2 here
        for (int c = 0; c < c_ch; c++) begin
            set_wr(c, 3'd0, 16'hFFFF, 2'b00);
            set_rd(c, 3'd3);
        end
        step(3'b100, 3'b100, 16'h00A5, 1'b0);
        step(3'b001, 3'b001, 16'h00A5, 1'b0);
        step(3'b010, 3'b010, 16'h00A5, 1'b0);
        step(3'b100, 3'b100, 16'h00A5, 1'b0);
        step(3'b001, 3'b001, 16'h00A5, 1'b0);
        step(3'b010, 3'b010, 16'h00A5, 1'b0);
        write_valid[1] = 1'b0;
        read_valid[1]  = 1'b0;
        step(3'b100, 3'b100, 16'h00A5, 1'b0);
        step(3'b001, 3'b001, 16'h00A5, 1'b0);
        step(3'b100, 3'b100, 16'h00A5, 1'b0);
        step(3'b001, 3'b001, 16'h00A5, 1'b0);
        write_valid = '0;
        read_valid  = '0;

        // Return data holds after the valid pulse
        repeat (3) @(negedge clock);
        chk("rd_data_hold", 32'(read_data), 32'h00A5);
        @(posedge clock);
        #1;

        // Zero-strobe writes to address 0 left it untouched
        set_rd(0, 3'd0);
        step(3'b000, 3'b001, 16'h0000, 1'b1);

        repeat (3) @(posedge clock);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
